// File: rtl/return_addr_stack.sv
// Circular return-address stack for the fetch unit: calls push pc+8, returns pop,
// and the backend can roll tos/count back to a per-branch checkpoint.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pd_valid,
    input  logic             pd_is_link,
    input  logic             pd_is_return,
    input  logic [31:0]      pd_pc,
    output logic [31:0]      top_addr,
    output logic             top_valid,
    output logic [PTR_W-1:0] ckpt_tos,
    output logic [CNT_W-1:0] ckpt_cnt,
    input  logic             recover_valid,
    input  logic [PTR_W-1:0] recover_tos,
    input  logic [CNT_W-1:0] recover_cnt
);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] tos_m1;
    logic [CNT_W-1:0] count;
    logic [31:0]      ret_addr;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;

    // No backpressure: any valid predecode op is consumed in the cycle it appears.
    assign push     = pd_valid & pd_is_link;
    assign pop      = pd_valid & pd_is_return;
    assign tos_m1   = tos - PTR_W'(1);
    assign ret_addr = pd_pc + 32'd8;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    assign top_addr  = mem[tos_m1];
    assign top_valid = ~empty;
    assign ckpt_tos  = tos;
    assign ckpt_cnt  = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (recover_valid) begin
            tos   <= recover_tos;
            count <= recover_cnt;
        end else if (push && pop && !empty) begin
            // JALR $31,$31: old top is the prediction, new link replaces it in place.
            mem[tos_m1] <= ret_addr;
        end else if (push) begin
            mem[tos] <= ret_addr;
            tos      <= tos + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            tos   <= tos_m1;
            count <= count - CNT_W'(1);
        end
    end

endmodule
